seg_scan_driver: RTL and testbench

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_scan_driver.sv | 87 ++++++++
 tb/tb_seg_scan_driver.sv | 119 +++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed 4-digit MM:SS seven-segment scanner with adjust-mode field blinking.
module seg_scan_driver #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic       adjust,
  input  logic       select,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);
  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);
  logic [SW-1:0] scan_cnt;
  logic [BW-1:0] blink_cnt, next_blink;
  logic [1:0]    idx, next_idx;
  logic [5:0]    snap_min, snap_sec, next_min, next_sec, value;
  logic [3:0]    digit;
  logic          phase, next_phase, primed, adjust_d;
  logic          scan_wrap, blink_wrap, frame, rise, blank;
  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0: enc = 7'b1000000;
      4'd1: enc = 7'b1111001;
      4'd2: enc = 7'b0100100;
      4'd3: enc = 7'b0110000;
      4'd4: enc = 7'b0011001;
      4'd5: enc = 7'b0010010;
      4'd6: enc = 7'b0000010;
      4'd7: enc = 7'b1111000;
      4'd8: enc = 7'b0000000;
      4'd9: enc = 7'b0010000;
      default: enc = 7'b1111111;
    endcase
  endfunction
  // The first edge out of reset opens a frame, so it captures like a 3->0 wrap.
  always_comb begin
    scan_wrap  = scan_cnt == SCAN_MAX;
    blink_wrap = blink_cnt == BLINK_MAX;
    frame      = !primed || (scan_wrap && idx == 2'd3);
    next_min   = frame ? minutes : snap_min;
    next_sec   = frame ? seconds : snap_sec;
    rise       = adjust && !adjust_d;
    next_blink = (rise || blink_wrap) ? '0 : blink_cnt + 1'b1;
    next_phase = rise ? 1'b1 : (blink_wrap ? !phase : phase);
    next_idx   = idx + 2'(scan_wrap);
    value      = next_idx[1] ? next_min : next_sec;
    digit      = next_idx[0] ? 4'(value / 6'd10) : 4'(value % 6'd10);
    blank      = adjust && !next_phase && (next_idx[1] == select);
  end
  // Outputs are decoded from post-edge state so they always describe the new digit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      scan_cnt  <= '0;
      idx       <= '0;
      blink_cnt <= '0;
      phase     <= 1'b1;
      snap_min  <= '0;
      snap_sec  <= '0;
      primed    <= 1'b0;
      adjust_d  <= 1'b0;
      an        <= 4'b1111;
      seg       <= 7'b1111111;
      dp        <= 1'b1;
    end else begin
      scan_cnt  <= scan_wrap ? '0 : scan_cnt + 1'b1;
      idx       <= next_idx;
      blink_cnt <= next_blink;
      phase     <= next_phase;
      snap_min  <= next_min;
      snap_sec  <= next_sec;
      primed    <= 1'b1;
      adjust_d  <= adjust;
      if (scan_wrap) begin
        an  <= ~(4'b0001 << next_idx);
        seg <= blank ? 7'b1111111 : enc(digit);
        dp  <= next_idx != 2'd2;
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: edge-count model of the scanner plus directed literal checkpoints.
module tb_seg_scan_driver;
  localparam int SD = 4;
  localparam int BD = 8;
  logic       clk = 1'b0;
  logic       rst, adjust, select;
  logic [5:0] minutes, seconds;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  int tests = 0, fails = 0;
  bit en = 1'b0;
  seg_scan_driver #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst(rst), .minutes(minutes), .seconds(seconds),
    .adjust(adjust), .select(select), .seg(seg), .an(an), .dp(dp)
  );
  always #5 clk = ~clk;
  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: glyph = 7'b1000000; 1: glyph = 7'b1111001; 2: glyph = 7'b0100100;
      3: glyph = 7'b0110000; 4: glyph = 7'b0011001; 5: glyph = 7'b0010010;
      6: glyph = 7'b0000010; 7: glyph = 7'b1111000; 8: glyph = 7'b0000000;
      default: glyph = 7'b0010000;
    endcase
  endfunction
  // Model in terms of edges since reset release: digit k is entered at edge SD*k,
  // frames start at edge 1 and every 4*SD edges, blink phase flips every BD edges from its anchor.
  int n, anchor, sm, ss, i, v, d;
  bit prev_adj, visible;
  logic [3:0] m_an;
  logic [6:0] m_seg;
  logic       m_dp;
  always @(posedge clk) begin
    if (!rst) begin
      n = 0; anchor = 0; prev_adj = 1'b0; sm = 0; ss = 0;
      m_an = 4'b1111; m_seg = 7'b1111111; m_dp = 1'b1;
    end else begin
      n++;
      if (adjust && !prev_adj) anchor = n;
      prev_adj = adjust;
      if (n == 1 || n % (4 * SD) == 0) begin
        sm = int'(minutes);
        ss = int'(seconds);
      end
      if (n % SD == 0) begin
        i = (n / SD) % 4;
        visible = ((n - anchor) / BD) % 2 == 0;
        v = (i >= 2) ? sm : ss;
        d = (i % 2 == 1) ? v / 10 : v % 10;
        m_an = 4'(~(4'b0001 << i));
        m_seg = (adjust && !visible && ((i >= 2) == (select == 1'b1))) ? 7'b1111111 : glyph(d);
        m_dp = i != 2;
      end
    end
  end
  always @(negedge clk) begin
    if (en) begin
      tests++;
      if (an !== m_an || seg !== m_seg || dp !== m_dp) begin
        fails++;
        $display("FAIL model t=%0t: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                 $time, an, seg, dp, m_an, m_seg, m_dp);
      end
    end
  end
  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic chk(input string name, input logic [3:0] ea, input logic [6:0] es, input logic ed);
    tests++;
    if ({an, seg, dp} !== {ea, es, ed}) begin
      fails++;
      $display("FAIL %s: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
               name, an, seg, dp, ea, es, ed);
    end
  endtask
  initial begin
    rst = 1'b0; minutes = 6'd12; seconds = 6'd34; adjust = 1'b0; select = 1'b0;
    step(3); en = 1'b1;
    chk("reset_blank", 4'b1111, 7'b1111111, 1'b1);
    rst = 1'b1;
    step(1);  chk("first_edge_dark", 4'b1111, 7'b1111111, 1'b1);
    step(3);  chk("sec_tens_3",  4'b1101, 7'b0110000, 1'b1);
    step(4);  chk("min_units_2", 4'b1011, 7'b0100100, 1'b0);
    step(4);  chk("min_tens_1",  4'b0111, 7'b1111001, 1'b1);
    step(4);  chk("sec_units_4", 4'b1110, 7'b0011001, 1'b1);
    step(4);  chk("tens_before_change", 4'b1101, 7'b0110000, 1'b1);
    seconds = 6'd35;
    step(12); chk("units_after_wrap_5", 4'b1110, 7'b0010010, 1'b1);
    step(15); adjust = 1'b1; select = 1'b1;
    step(1);  chk("adj_sec_visible", 4'b1110, 7'b0010010, 1'b1);
    step(8);  chk("adj_min_units_blank", 4'b1011, 7'b1111111, 1'b0);
    step(4);  chk("adj_min_tens_blank",  4'b0111, 7'b1111111, 1'b1);
    step(4);  chk("adj_sec_units_shown", 4'b1110, 7'b0010010, 1'b1);
    select = 1'b0;
    step(4);  chk("sel_sec_tens_shown",  4'b1101, 7'b0110000, 1'b1);
    step(4);  chk("sel_moved_min_shown", 4'b1011, 7'b0100100, 1'b0);
    adjust = 1'b0;
    step(19); adjust = 1'b1;
    step(9);  chk("rearm_sec_tens_blank", 4'b1101, 7'b1111111, 1'b1);
    step(4);  chk("rearm_min_units", 4'b1011, 7'b0100100, 1'b0);
    adjust = 1'b0; minutes = 6'd59; seconds = 6'd0;
    step(8);  chk("sec_units_0", 4'b1110, 7'b1000000, 1'b1);
    step(8);  chk("min_units_9_dp", 4'b1011, 7'b0010000, 1'b0);
    step(4);  chk("min_tens_5", 4'b0111, 7'b0010010, 1'b1);
    seconds = 6'd63;
    step(4);  chk("sec63_units_3", 4'b1110, 7'b0110000, 1'b1);
    step(4);  chk("sec63_tens_6",  4'b1101, 7'b0000010, 1'b1);
    step(2);  rst = 1'b0;
    step(1);  chk("midframe_reset", 4'b1111, 7'b1111111, 1'b1);
    rst = 1'b1;
    step(1);  chk("restart_dark", 4'b1111, 7'b1111111, 1'b1);
    step(3);  chk("restart_sec_tens", 4'b1101, 7'b0000010, 1'b1);
    step(4);  chk("restart_min_units", 4'b1011, 7'b0010000, 1'b0);
    step(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
